// File: rtl/lif_array.sv
// lif_array: time-multiplexed array of leaky integrate-and-fire neurons.
//
// One shared update datapath visits every neuron once per sweep. A sweep
// is started by `tick` while idle; each enabled sweep cycle updates
// neuron[idx] and advances idx. After the last neuron, the sweep's spike
// accumulator is published on `spikes` and `done` pulses for one cycle.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   ena              global enable; low freezes every register
//   tick             sweep request (honoured only when idle and enabled)
//   base_current     per-neuron current, neuron i at [i*CUR_W +: CUR_W]
//   coupling_in      unsigned coupling magnitude
//   mode             00 base, 01 base+cpl, 10 base-cpl, 11 lateral
//   threshold        spike threshold (v >= threshold fires)
//   reset_potential  potential after a spike / during refractory sweeps
//   leak             leak subtracted per update (only when v > leak)
//   refrac_period    refractory sweeps following a spike
//   potential_sel    readout index
//   potential_out    combinational potential of the selected neuron
//   spikes           spike vector of the last completed sweep
//   busy             sweep in progress
//   done             one-cycle pulse at sweep completion

// Per-neuron state: potential and refractory counter, written only on
// that neuron's update cycle.
module lif_cell #(
  parameter int WIDTH    = 8,
  parameter int REFRAC_W = 3,
  parameter int V_INIT   = 50
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we_i,
  input  logic [WIDTH-1:0]    v_d_i,
  input  logic [REFRAC_W-1:0] rc_d_i,
  output logic [WIDTH-1:0]    v_o,
  output logic [REFRAC_W-1:0] rc_o
);
  localparam logic [WIDTH-1:0] V_INIT_W = WIDTH'(V_INIT);

  logic [WIDTH-1:0]    v_q;
  logic [REFRAC_W-1:0] rc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q  <= V_INIT_W;
      rc_q <= '0;
    end else if (we_i) begin
      v_q  <= v_d_i;
      rc_q <= rc_d_i;
    end
  end

  assign v_o  = v_q;
  assign rc_o = rc_q;
endmodule

module lif_array #(
  parameter int N_NEURONS = 4,
  parameter int WIDTH     = 8,
  parameter int CUR_W     = 5,
  parameter int REFRAC_W  = 3,
  parameter int V_INIT    = 50,
  localparam int IDX_W    = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ena,
  input  logic                         tick,
  input  logic [N_NEURONS*CUR_W-1:0]   base_current,
  input  logic [WIDTH-1:0]             coupling_in,
  input  logic [1:0]                   mode,
  input  logic [WIDTH-1:0]             threshold,
  input  logic [WIDTH-1:0]             reset_potential,
  input  logic [WIDTH-1:0]             leak,
  input  logic [REFRAC_W-1:0]          refrac_period,
  input  logic [IDX_W-1:0]             potential_sel,
  output logic [WIDTH-1:0]             potential_out,
  output logic [N_NEURONS-1:0]         spikes,
  output logic                         busy,
  output logic                         done
);
  // Wide enough that v + base + coupling never wraps before the clamp.
  localparam int MAXW  = (WIDTH > CUR_W) ? WIDTH : CUR_W;
  localparam int SUM_W = MAXW + 3;
  localparam logic signed [SUM_W-1:0] S_MAX =
    $signed({{(SUM_W-WIDTH){1'b0}}, {WIDTH{1'b1}}});
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

  typedef enum logic {S_IDLE, S_SWEEP} state_t;

  state_t                  state_q;
  logic [IDX_W-1:0]        idx_q;
  logic                    busy_q, done_q;
  logic [N_NEURONS-1:0]    spikes_q, prev_q, acc_q, acc_d;

  logic [N_NEURONS-1:0][WIDTH-1:0]    v_vec;
  logic [N_NEURONS-1:0][REFRAC_W-1:0] rc_vec;

  logic [WIDTH-1:0]     v_cur, v_nxt, v_sat;
  logic [REFRAC_W-1:0]  rc_cur, rc_nxt;
  logic [CUR_W-1:0]     base_cur;
  logic [N_NEURONS-1:0] self_mask;
  logic                 spk, lateral_hit, upd_en;

  logic signed [SUM_W-1:0] s_v, s_base, s_cpl, s_leak, s_cur, s_sum;

  assign upd_en = ena && (state_q == S_SWEEP);

  // Select the neuron under update; self_mask is its one-hot position.
  always_comb begin
    v_cur     = '0;
    rc_cur    = '0;
    base_cur  = '0;
    self_mask = '0;
    for (int i = 0; i < N_NEURONS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        v_cur        = v_vec[i];
        rc_cur       = rc_vec[i];
        base_cur     = base_current[i*CUR_W +: CUR_W];
        self_mask[i] = 1'b1;
      end
    end
  end

  // Lateral coupling ignores the neuron's own spike from the last sweep.
  assign lateral_hit = |(prev_q & ~self_mask);

  // Shared integrate datapath, all operands zero-extended before signing.
  always_comb begin
    s_v    = $signed({{(SUM_W-WIDTH){1'b0}}, v_cur});
    s_base = $signed({{(SUM_W-CUR_W){1'b0}}, base_cur});
    s_cpl  = $signed({{(SUM_W-WIDTH){1'b0}}, coupling_in});
    s_leak = (v_cur > leak) ? $signed({{(SUM_W-WIDTH){1'b0}}, leak}) : '0;
    case (mode)
      2'b00:   s_cur = s_base;
      2'b01:   s_cur = s_base + s_cpl;
      2'b10:   s_cur = s_base - s_cpl;
      default: s_cur = lateral_hit ? (s_base + s_cpl) : s_base;
    endcase
    s_sum = s_v + s_cur - s_leak;
    if (s_sum < 0)          v_sat = '0;
    else if (s_sum > S_MAX) v_sat = '1;
    else                    v_sat = s_sum[WIDTH-1:0];
  end

  // Refractory beats threshold, threshold beats integration.
  always_comb begin
    v_nxt  = v_sat;
    rc_nxt = rc_cur;
    spk    = 1'b0;
    if (rc_cur != '0) begin
      v_nxt  = reset_potential;
      rc_nxt = rc_cur - REFRAC_W'(1);
    end else if (v_cur >= threshold) begin
      v_nxt  = reset_potential;
      rc_nxt = refrac_period;
      spk    = 1'b1;
    end
  end

  assign acc_d = (acc_q & ~self_mask) | (spk ? self_mask : '0);

  for (genvar g = 0; g < N_NEURONS; g++) begin : g_cell
    lif_cell #(
      .WIDTH   (WIDTH),
      .REFRAC_W(REFRAC_W),
      .V_INIT  (V_INIT)
    ) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .we_i  (upd_en && self_mask[g]),
      .v_d_i (v_nxt),
      .rc_d_i(rc_nxt),
      .v_o   (v_vec[g]),
      .rc_o  (rc_vec[g])
    );
  end

  // Sweep sequencer. Disabled cycles hold everything, done included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      spikes_q <= '0;
      prev_q   <= '0;
      acc_q    <= '0;
    end else if (ena) begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (tick) begin
            state_q <= S_SWEEP;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            acc_q   <= '0;
          end
        end
        default: begin
          acc_q <= acc_d;
          if (idx_q == LAST_IDX) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            spikes_q <= acc_d;
            prev_q   <= acc_d;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
      endcase
    end
  end

  // Combinational readout; out-of-range selects read as zero.
  always_comb begin
    potential_out = '0;
    for (int i = 0; i < N_NEURONS; i++)
      if (potential_sel == IDX_W'(i)) potential_out = v_vec[i];
  end

  assign spikes = spikes_q;
  assign busy   = busy_q;
  assign done   = done_q;
endmodule

// File: tb/tb_lif_array.sv
// Self-checking bench for lif_array (N=4, WIDTH=8). Table rows configure
// the array, run a number of sweeps and push the expected end-of-row state
// to a scoreboard that is popped when the final sweep's done pulse shows.
// Handshake, stall and mid-sweep reset are hand-written sequences.
module tb_lif_array;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b1;
  logic        tick = 1'b0;
  logic [N-1:0][4:0] base = '0;
  logic [7:0]  coupling_in = '0;
  logic [1:0]  mode = '0;
  logic [7:0]  threshold = 8'd200;
  logic [7:0]  reset_potential = 8'd50;
  logic [7:0]  leak = '0;
  logic [2:0]  refrac_period = '0;
  logic [1:0]  potential_sel = '0;
  logic [7:0]  potential_out;
  logic [N-1:0] spikes;
  logic        busy, done;

  always #5 clk = ~clk;

  lif_array dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .tick(tick),
    .base_current(base), .coupling_in(coupling_in), .mode(mode),
    .threshold(threshold), .reset_potential(reset_potential), .leak(leak),
    .refrac_period(refrac_period), .potential_sel(potential_sel),
    .potential_out(potential_out), .spikes(spikes), .busy(busy), .done(done)
  );

  typedef struct {
    bit          rst;
    logic [1:0]  mode;
    logic [N-1:0][4:0] base;
    logic [7:0]  cpl, lk, thr, rp;
    logic [2:0]  ref_p;
    int          nsw;
    int          ev[N];
    logic [N-1:0] es;
  } vec_t;

  typedef struct {
    int          ev[N];
    logic [N-1:0] es;
  } exp_t;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  task automatic chk(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_pots(input string tag, input int ev[N]);
    for (int i = 0; i < N; i++) begin
      potential_sel = 2'(i);
      #1;
      chk($sformatf("%s pot[%0d]", tag, i), int'(potential_out), ev[i]);
    end
  endtask

  // Called at a negedge while idle; returns at the negedge where done is seen.
  task automatic do_sweep(input bit check, input exp_t e, input string tag);
    int   n;
    exp_t got;
    if (check) sb.push_back(e);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk({tag, " done timeout"}, 0, 1);
    if (check && sb.size() > 0) begin
      got = sb.pop_front();
      chk({tag, " spikes"}, int'(spikes), int'(got.es));
      chk_pots(tag, got.ev);
      chk({tag, " busy"}, int'(busy), 0);
    end
  endtask

  vec_t tbl[$];

  function automatic vec_t mk(bit r, logic [1:0] m, int b0, int b1, int b2,
                              int b3, int c, int l, int t, int rp, int rf,
                              int ns, int e0, int e1, int e2, int e3, int es);
    vec_t v;
    v.rst = r; v.mode = m;
    v.base[0] = 5'(b0); v.base[1] = 5'(b1); v.base[2] = 5'(b2); v.base[3] = 5'(b3);
    v.cpl = 8'(c); v.lk = 8'(l); v.thr = 8'(t); v.rp = 8'(rp); v.ref_p = 3'(rf);
    v.nsw = ns;
    v.ev[0] = e0; v.ev[1] = e1; v.ev[2] = e2; v.ev[3] = e3;
    v.es = 4'(es);
    return v;
  endfunction

  initial begin
    exp_t e;
    int   init_v[N];

    // Integration: +5 per sweep, fires at sweep 31 when v reaches 200.
    tbl.push_back(mk(1, 2'b00, 10,10,10,10, 0, 5, 200, 50, 0,  1,  55, 55, 55, 55, 0));
    tbl.push_back(mk(0, 2'b00, 10,10,10,10, 0, 5, 200, 50, 0,  9, 100,100,100,100, 0));
    tbl.push_back(mk(0, 2'b00, 10,10,10,10, 0, 5, 200, 50, 0, 20, 200,200,200,200, 0));
    tbl.push_back(mk(0, 2'b00, 10,10,10,10, 0, 5, 200, 50, 0,  1,  50, 50, 50, 50, 15));
    // Refractory period 2: two held sweeps then integration resumes.
    tbl.push_back(mk(1, 2'b00, 10,10,10,10, 0, 5, 200, 50, 2, 31,  50, 50, 50, 50, 15));
    tbl.push_back(mk(0, 2'b00, 10,10,10,10, 0, 5, 200, 50, 2,  1,  50, 50, 50, 50, 0));
    tbl.push_back(mk(0, 2'b00, 10,10,10,10, 0, 5, 200, 50, 2,  1,  50, 50, 50, 50, 0));
    tbl.push_back(mk(0, 2'b00, 10,10,10,10, 0, 5, 200, 50, 2,  1,  55, 55, 55, 55, 0));
    // Upper clamp: 50 -> 208 -> 255, then 255 >= 255 fires.
    tbl.push_back(mk(1, 2'b01, 31,31,31,31, 127, 0, 255, 50, 0, 1, 208,208,208,208, 0));
    tbl.push_back(mk(0, 2'b01, 31,31,31,31, 127, 0, 255, 50, 0, 1, 255,255,255,255, 0));
    tbl.push_back(mk(0, 2'b01, 31,31,31,31, 127, 0, 255, 50, 0, 1,  50, 50, 50, 50, 15));
    // Lower clamp: 50 + 0 - 100 - 5 -> 0, and stays 0 (leak not applied at 0).
    tbl.push_back(mk(1, 2'b10, 0,0,0,0, 100, 5, 200, 50, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 2'b10, 0,0,0,0, 100, 5, 200, 50, 0, 1, 0, 0, 0, 0, 0));
    // Lateral: neuron 0 alone fires at sweep 3; next sweep others get +20.
    tbl.push_back(mk(1, 2'b00, 31,0,0,0, 20, 0, 100, 50, 0, 3,  50, 50, 50, 50, 1));
    tbl.push_back(mk(0, 2'b11, 31,0,0,0, 20, 0, 100, 50, 0, 1,  81, 70, 70, 70, 0));
    tbl.push_back(mk(0, 2'b11, 31,0,0,0, 20, 0, 100, 50, 0, 1, 112, 70, 70, 70, 0));
    // Leak boundary: leak only when v is strictly greater than it.
    tbl.push_back(mk(1, 2'b00, 10,10,10,10, 0, 50, 200, 50, 0, 1, 60, 60, 60, 60, 0));
    tbl.push_back(mk(0, 2'b00, 10,10,10,10, 0, 50, 200, 50, 0, 1, 20, 20, 20, 20, 0));
    tbl.push_back(mk(0, 2'b00, 10,10,10,10, 0, 50, 200, 50, 0, 1, 30, 30, 30, 30, 0));

    for (int i = 0; i < N; i++) init_v[i] = 50;

    // Reset state.
    do_reset();
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst spikes", int'(spikes), 0);
    chk_pots("rst", init_v);

    // Table-driven vectors.
    for (int r = 0; r < tbl.size(); r++) begin
      if (tbl[r].rst) do_reset();
      @(negedge clk);
      mode = tbl[r].mode; base = tbl[r].base; coupling_in = tbl[r].cpl;
      leak = tbl[r].lk; threshold = tbl[r].thr; reset_potential = tbl[r].rp;
      refrac_period = tbl[r].ref_p;
      e.ev = tbl[r].ev;
      e.es = tbl[r].es;
      for (int s = 0; s < tbl[r].nsw; s++)
        do_sweep(s == tbl[r].nsw - 1, e, $sformatf("row%0d", r));
    end

    // Handshake: done only after the 5th edge; tick while busy is dropped.
    do_reset();
    mode = 2'b00; base = '0; leak = '0; threshold = 8'd200;
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    chk("hs e1 busy", int'(busy), 1); chk("hs e1 done", int'(done), 0);
    @(negedge clk); tick = 1'b1;
    chk("hs e2 busy", int'(busy), 1); chk("hs e2 done", int'(done), 0);
    @(negedge clk); tick = 1'b0;
    chk("hs e3 done", int'(done), 0);
    @(negedge clk);
    chk("hs e4 busy", int'(busy), 1); chk("hs e4 done", int'(done), 0);
    @(negedge clk);
    chk("hs e5 done", int'(done), 1); chk("hs e5 busy", int'(busy), 0);
    @(negedge clk);
    chk("hs e6 done", int'(done), 0); chk("hs e6 busy", int'(busy), 0);

    // Stall: ena low for 3 cycles mid-sweep pushes done from edge 5 to 8.
    tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    @(negedge clk); ena = 1'b0;
    for (int k = 3; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("stall e%0d busy", k), int'(busy), 1);
      chk($sformatf("stall e%0d done", k), int'(done), 0);
    end
    ena = 1'b1;
    @(negedge clk); chk("stall e6 done", int'(done), 0);
    @(negedge clk); chk("stall e7 done", int'(done), 0);
    @(negedge clk); chk("stall e8 done", int'(done), 1);
    // done is held while disabled, then drops on the next enabled edge.
    ena = 1'b0;
    @(negedge clk); chk("stall hold done", int'(done), 1);
    ena = 1'b1;
    @(negedge clk); chk("stall drop done", int'(done), 0);

    // Reset mid-sweep after potentials moved and spikes were published.
    do_reset();
    mode = 2'b01; base = {4{5'd31}}; coupling_in = 8'd127; leak = '0;
    threshold = 8'd100; reset_potential = 8'd50; refrac_period = 3'd0;
    e.es = '0;
    do_sweep(1'b0, e, "pre1");
    do_sweep(1'b0, e, "pre2");
    chk("pre spikes", int'(spikes), 15);
    tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst busy", int'(busy), 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("midrst spikes", int'(spikes), 0);
    chk("midrst done", int'(done), 0);
    chk("midrst busy2", int'(busy), 0);
    chk_pots("midrst", init_v);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
